// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register addresses,
// FSM state encoding, default source count and the priority helper.
package int_ctrl_pkg;

   localparam int N_SRC_DEF = 5;

   localparam logic [1:0] INTC_PENDING = 2'd0;
   localparam logic [1:0] INTC_MASK    = 2'd1;
   localparam logic [1:0] INTC_MODE    = 2'd2;
   localparam logic [1:0] INTC_EOI     = 2'd3;

   // Encoding is software-visible through STATUS[7:6].
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } intc_state_t;

   // Index of the highest set bit (highest index wins); 0 when v is 0.
   function automatic logic [2:0] hi_idx(input logic [7:0] v);
      hi_idx = '0;
      for (int i = 0; i < 8; i++)
         if (v[i]) hi_idx = 3'(i);
   endfunction

endpackage

// File: rtl/int_sync.sv
// Single-lane input synchroniser: SYNC_STAGES flop chain followed by one
// history flop, giving the synchronised level and a one-cycle rise pulse.
//   clk, rst    : clock, async active-low reset
//   async_in    : raw line, asynchronous to clk
//   sync        : synchronised level
//   rise        : sync & ~previous sync
module int_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync,
   output logic rise
);

   logic [SYNC_STAGES-1:0] ff;
   logic                   hist;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ff   <= '0;
         hist <= 1'b0;
      end else begin
         ff   <= {ff[SYNC_STAGES-2:0], async_in};
         hist <= ff[SYNC_STAGES-1];
      end
   end

   assign sync = ff[SYNC_STAGES-1];
   assign rise = sync & ~hist;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller in front of the core's INT input. Synchronises the
// external lines, latches them as pending (edge or level per source), masks
// them and presents one prioritised, registered one-hot request.
//   clk, rst       : clock, async active-low reset
//   src_in         : raw interrupt lines
//   we/addr/wd/rd  : register window (PENDING, MASK, MODE, EOI/STATUS)
//   int_ack        : core accepts the current request
//   int_out/int_id : registered one-hot request and its index
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int N_SRC       = N_SRC_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_in,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wd,
   output logic [31:0]      rd,
   input  logic             int_ack,
   output logic [N_SRC-1:0] int_out,
   output logic [2:0]       int_id
);

   generate
      if (N_SRC > 8 || N_SRC < 1) begin : g_nsrc_chk
         $error("int_ctrl: N_SRC must be 1..8 to fit the 3-bit int_id");
      end
      if (SYNC_STAGES < 2) begin : g_sync_chk
         $error("int_ctrl: SYNC_STAGES must be at least 2");
      end
   endgenerate

   logic [N_SRC-1:0] sync, rise;
   logic [N_SRC-1:0] pending, mask, mode;
   logic [N_SRC-1:0] elig, w1c, ack_clr, pend_nxt;
   logic [N_SRC-1:0] int_out_nxt, id_bit;
   logic [2:0]       win, int_id_nxt;
   logic             wr_pend, wr_mask, wr_mode, wr_eoi, ack_take, id_elig;
   intc_state_t      state, state_nxt;

   // Upper write-data bits are architecturally ignored.
   logic unused_wd;
   assign unused_wd = ^wd[31:N_SRC];

   for (genvar i = 0; i < N_SRC; i++) begin : g_sync
      int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk      (clk),
         .rst      (rst),
         .async_in (src_in[i]),
         .sync     (sync[i]),
         .rise     (rise[i])
      );
   end

   assign wr_pend  = we && (addr == INTC_PENDING);
   assign wr_mask  = we && (addr == INTC_MASK);
   assign wr_mode  = we && (addr == INTC_MODE);
   assign wr_eoi   = we && (addr == INTC_EOI);

   assign elig     = pending & mask;
   assign win      = hi_idx(8'(elig));
   assign id_bit   = N_SRC'(1) << int_id;
   assign id_elig  = |(elig & id_bit);
   assign ack_take = (state == ST_REQ) && int_ack;
   assign ack_clr  = ack_take ? id_bit : '0;
   assign w1c      = wr_pend ? wd[N_SRC-1:0] : '0;

   // Level sources mirror the synchronised line; edge sources hold until
   // cleared, and a rise in the same cycle as a clear keeps the bit set.
   assign pend_nxt = (mode & sync) | (~mode & ((pending & ~(w1c | ack_clr)) | rise));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
         mask    <= '0;
         mode    <= '0;
      end else begin
         pending <= pend_nxt;
         if (wr_mask) mask <= wd[N_SRC-1:0];
         if (wr_mode) mode <= wd[N_SRC-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         int_out <= '0;
         int_id  <= '0;
      end else begin
         state   <= state_nxt;
         int_out <= int_out_nxt;
         int_id  <= int_id_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      int_out_nxt = int_out;
      int_id_nxt  = int_id;
      case (state)
         ST_IDLE: begin
            if (|elig) begin
               state_nxt   = ST_REQ;
               int_out_nxt = N_SRC'(1) << win;
               int_id_nxt  = win;
            end
         end
         ST_REQ: begin
            if (int_ack) begin
               state_nxt = ST_SVC;
            end else if (!id_elig) begin
               state_nxt   = ST_IDLE;
               int_out_nxt = '0;
            end else if (win != int_id) begin
               // int_id is still eligible, so any other winner outranks it.
               int_out_nxt = N_SRC'(1) << win;
               int_id_nxt  = win;
            end
         end
         ST_SVC: begin
            int_out_nxt = '0;
            if (wr_eoi) begin
               state_nxt  = ST_IDLE;
               int_id_nxt = '0;
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            int_out_nxt = '0;
            int_id_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      rd = '0;
      case (addr)
         INTC_PENDING: rd[N_SRC-1:0] = pending;
         INTC_MASK:    rd[N_SRC-1:0] = mask;
         INTC_MODE:    rd[N_SRC-1:0] = mode;
         default: begin
            rd[7:6] = state;
            rd[2:0] = int_id;
         end
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

   localparam int N = 5;
   localparam logic [1:0] A_PEND = 2'd0, A_MASK = 2'd1, A_MODE = 2'd2, A_EOI = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  src_in = '0;
   logic          we = 1'b0;
   logic [1:0]    addr = '0;
   logic [31:0]   wd = '0;
   logic [31:0]   rd;
   logic          int_ack = 1'b0;
   logic [N-1:0]  int_out;
   logic [2:0]    int_id;

   int n_chk  = 0;
   int n_fail = 0;

   int_ctrl #(.N_SRC(N), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .src_in(src_in), .we(we), .addr(addr), .wd(wd),
      .rd(rd), .int_ack(int_ack), .int_out(int_out), .int_id(int_id)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wd = d;
      step();
      we = 1'b0;
   endtask

   task automatic rreg(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rd;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
   endtask

   // Reference: highest set bit of a vector, or -1 if empty.
   function automatic int top_bit(input logic [N-1:0] v);
      top_bit = -1;
      for (int i = 0; i < N; i++) if (v[i]) top_bit = i;
   endfunction

   initial begin
      logic [31:0]  r;
      logic [N-1:0] pend_m, prev_s, s, c, m, e;
      int           w;

      // Reset state
      step(2);
      chk("rst_int_out", 32'(int_out), 0);
      chk("rst_int_id", 32'(int_id), 0);
      rreg(A_PEND, r); chk("rst_pending", r, 0);
      rreg(A_MASK, r); chk("rst_mask", r, 0);
      rreg(A_MODE, r); chk("rst_mode", r, 0);
      rreg(A_EOI, r);  chk("rst_status", r, 0);
      rst = 1'b1;
      step();

      // Basic edge, including request latency
      wr(A_MASK, 32'h1F);
      src_in = 5'b00100; step(); src_in = '0;
      step(2);
      chk("lat_early_out", 32'(int_out), 0);
      step();
      chk("basic_out", 32'(int_out), 32'h04);
      chk("basic_id", 32'(int_id), 2);
      ack(); step();
      rreg(A_PEND, r); chk("basic_pend_clr", r, 0);
      rreg(A_EOI, r);  chk("basic_status_svc", r, 32'h82);
      chk("basic_svc_out", 32'(int_out), 0);
      wr(A_EOI, 32'hDEAD);
      rreg(A_EOI, r);  chk("basic_status_idle", r, 0);

      // Priority and simultaneity
      src_in = 5'b11111; step(); src_in = '0;
      step(3);
      for (int id = 4; id >= 0; id--) begin
         chk($sformatf("prio_out%0d", id), 32'(int_out), 32'(1) << id);
         chk($sformatf("prio_id%0d", id), 32'(int_id), 32'(id));
         ack();
         wr(A_EOI, 0);
         step();
      end
      rreg(A_PEND, r); chk("prio_pend_end", r, 0);
      chk("prio_out_end", 32'(int_out), 0);

      // Masking
      wr(A_MASK, 0);
      src_in = 5'b00010; step(); src_in = '0;
      step(4);
      chk("mask_no_out", 32'(int_out), 0);
      rreg(A_PEND, r); chk("mask_pend", r, 32'h02);
      wr(A_MASK, 32'h02); step();
      chk("mask_en_out", 32'(int_out), 32'h02);
      wr(A_MASK, 0); step();
      chk("mask_drop_out", 32'(int_out), 0);
      rreg(A_EOI, r);  chk("mask_drop_state", r[7:6], 0);
      rreg(A_PEND, r); chk("mask_pend_kept", r, 32'h02);

      // Preemption in REQ
      wr(A_MASK, 32'h1F); step();
      chk("pre_req1_out", 32'(int_out), 32'h02);
      src_in = 5'b10000; step(); src_in = '0;
      step(3);
      chk("pre_out", 32'(int_out), 32'h10);
      chk("pre_id", 32'(int_id), 4);
      ack(); step();
      rreg(A_PEND, r); chk("pre_pend_only4", r, 32'h02);
      wr(A_EOI, 0); step();
      chk("pre_rereq_out", 32'(int_out), 32'h02);
      ack(); wr(A_EOI, 0); step();
      rreg(A_PEND, r); chk("pre_pend_end", r, 0);

      // Level mode
      wr(A_MODE, 32'h08);
      src_in = 5'b01000;
      step(4);
      chk("lvl_out", 32'(int_out), 32'h08);
      ack(); step();
      wr(A_PEND, 32'h08);
      rreg(A_PEND, r); chk("lvl_w1c_pend", r, 32'h08);
      rreg(A_EOI, r);  chk("lvl_status", r, 32'h83);
      wr(A_EOI, 0); step();
      chk("lvl_rereq_out", 32'(int_out), 32'h08);
      chk("lvl_rereq_id", 32'(int_id), 3);
      src_in = '0;
      step(2);
      rreg(A_PEND, r); chk("lvl_pend_hold", r, 32'h08);
      step();
      rreg(A_PEND, r); chk("lvl_pend_drop", r, 0);
      step();
      chk("lvl_out_drop", 32'(int_out), 0);
      wr(A_MODE, 0);

      // Randomised edge-mode pending/priority against a set-level model
      wr(A_MASK, 0);
      step(2);
      pend_m = '0; prev_s = '0;
      for (int it = 0; it < 12; it++) begin
         s = N'($urandom_range(0, 31));
         src_in = s;
         pend_m |= s & ~prev_s;
         prev_s = s;
         step(4);
         if ($urandom_range(0, 1) == 1) begin
            c = N'($urandom_range(0, 31));
            wr(A_PEND, 32'(c));
            pend_m &= ~c;
         end
         rreg(A_PEND, r); chk($sformatf("rnd_pend%0d", it), r, 32'(pend_m));
         m = N'($urandom_range(0, 31));
         wr(A_MASK, 32'(m));
         step(2);
         e = pend_m & m;
         w = top_bit(e);
         if (w < 0) begin
            chk($sformatf("rnd_idle%0d", it), 32'(int_out), 0);
         end else begin
            chk($sformatf("rnd_out%0d", it), 32'(int_out), 32'(1) << w);
            chk($sformatf("rnd_id%0d", it), 32'(int_id), 32'(w));
         end
         wr(A_MASK, 0);
         step(2);
         chk($sformatf("rnd_off%0d", it), 32'(int_out), 0);
      end
      src_in = '0;
      step(4);
      wr(A_PEND, 32'h1F);

      // Reset mid-service
      wr(A_MASK, 32'h1F);
      src_in = 5'b10101; step(); src_in = '0;
      step(3);
      chk("rs_req_id", 32'(int_id), 4);
      ack(); step();
      rreg(A_PEND, r); chk("rs_pend_svc", r, 32'h05);
      rreg(A_EOI, r);  chk("rs_state_svc", r, 32'h84);
      #2;
      wr(A_MODE, 0);
      #3 rst = 1'b0;
      #1;
      chk("rs_int_out", 32'(int_out), 0);
      chk("rs_int_id", 32'(int_id), 0);
      rreg(A_PEND, r); chk("rs_pend", r, 0);
      rreg(A_MASK, r); chk("rs_mask", r, 0);
      rreg(A_MODE, r); chk("rs_mode", r, 0);
      step();
      rst = 1'b1;
      step(2);
      rreg(A_EOI, r); chk("rs_state_after", r, 0);
      chk("rs_out_after", 32'(int_out), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
